// File: rtl/fpu_fp32_pkg.sv
// Shared definitions for the FP32 FPU issue block.
//   - FPU op codes as driven on opMode
//   - FSM state encoding (DIVM only exists when FPU_ISSUE_SPLITDIV_EN is defined)
//   - default per-op latencies in cycles
// Optional feature macro: FPU_ISSUE_SPLITDIV_EN
package fpu_fp32_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_ABS  = 4'd5;
  localparam logic [3:0] OP_NEG  = 4'd6;
  localparam logic [3:0] OP_RCP  = 4'd7;
  localparam logic [3:0] OP_SQRT = 4'd8;

  localparam int LAT_ADD_DEF = 2;
  localparam int LAT_MUL_DEF = 2;
  localparam int LAT_RCP_DEF = 2;
  localparam int LAT_DIV_DEF = 4;
  localparam int LAT_SMP_DEF = 1;

`ifdef FPU_ISSUE_SPLITDIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIVM = 2'd2,
    ST_RESP = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/fpu_fp32_issue_if.sv
// Request/response bus between the integer pipeline and the FPU issue block.
//   master : pipeline side (drives requests, flush, rspReady)
//   slave  : issue block side (drives reqReady and the response)
// Signals
//   reqValid/reqReady       request handshake
//   reqOp/reqSrcA/reqSrcB   op code and FP32 operands
//   reqTag                  opaque tag returned with the result
//   flush                   abort in-flight op, drop pending response
//   rspValid/rspReady       response handshake
//   rspData/rspTag          FP32 result and its tag
interface fpu_fp32_issue_if #(
  parameter int TAG_W = 4
);

  logic             reqValid;
  logic             reqReady;
  logic [3:0]       reqOp;
  logic [31:0]      reqSrcA;
  logic [31:0]      reqSrcB;
  logic [TAG_W-1:0] reqTag;
  logic             flush;
  logic             rspValid;
  logic             rspReady;
  logic [31:0]      rspData;
  logic [TAG_W-1:0] rspTag;

  modport master (
    output reqValid, reqOp, reqSrcA, reqSrcB, reqTag, flush, rspReady,
    input  reqReady, rspValid, rspData, rspTag
  );

  modport slave (
    input  reqValid, reqOp, reqSrcA, reqSrcB, reqTag, flush, rspReady,
    output reqReady, rspValid, rspData, rspTag
  );

endinterface

// File: rtl/fpu_fp32_lat_lut.sv
// Combinational op-code to latency lookup for the FPU issue block.
// Ports
//   op   in  4  FPU op code as it will be issued
//   lat  out 4  cycles the FPU needs for that op (1..15)
// Codes 0, 5, 6, 8 and 9..15 all use the simple-op latency.
module fpu_fp32_lat_lut
  import fpu_fp32_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_RCP = LAT_RCP_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int LAT_SMP = LAT_SMP_DEF
) (
  input  logic [3:0] op,
  output logic [3:0] lat
);

  always_comb begin
    lat = 4'(LAT_SMP);
    case (op)
      OP_ADD, OP_SUB:                    lat = 4'(LAT_ADD);
      OP_MUL:                            lat = 4'(LAT_MUL);
      OP_RCP:                            lat = 4'(LAT_RCP);
      OP_DIV:                            lat = 4'(LAT_DIV);
      OP_NONE, OP_ABS, OP_NEG, OP_SQRT:  lat = 4'(LAT_SMP);
      default:                           lat = 4'(LAT_SMP);
    endcase
  end

endmodule

// File: rtl/fpu_fp32_issue.sv
// Initiator side of the FP32 FPU op interface. Accepts one request at a time,
// drives opMode/srca/srcb stable for the op latency, captures dst and returns
// it with the request tag over the response handshake.
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   bus            fpu_fp32_issue_if.slave: request/response/flush
//   fpuOpMode      op code to the FPU (0 whenever no op is executing)
//   fpuSrcA/B      operands to the FPU
//   fpuDst         result from the FPU
//   busy           high in any state other than IDLE
// Optional feature macro: FPU_ISSUE_SPLITDIV_EN
//   defined : DIV runs as RCP(srcb) then MUL(srcA, rcp) via the DIVM state
//   undefined: DIV is issued directly with LAT_DIV
//
// state | meaning
// IDLE  | ready for a request, FPU idle (opMode 0)
// EXEC  | op (or RCP half of a split DIV) on the FPU, counting down latency
// DIVM  | MUL half of a split DIV, srcb = captured reciprocal
// RESP  | result held on the response port until consumed
module fpu_fp32_issue
  import fpu_fp32_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_RCP = LAT_RCP_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int LAT_SMP = LAT_SMP_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_fp32_issue_if.slave      bus,
  output logic [3:0]           fpuOpMode,
  output logic [31:0]          fpuSrcA,
  output logic [31:0]          fpuSrcB,
  input  logic [31:0]          fpuDst,
  output logic                 busy
);

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       op_q;
  logic [31:0]      src_a_q;
  logic [31:0]      src_b_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;
  logic [3:0]       issue_op;
  logic [3:0]       lat;
  logic             ready;
  logic             accept;
  logic             cnt_zero;
  logic             counting;
`ifdef FPU_ISSUE_SPLITDIV_EN
  logic             split_q;
  logic [31:0]      rcp_q;
`endif

  // A split DIV starts by issuing the reciprocal of srcb.
  always_comb begin
    issue_op = bus.reqOp;
`ifdef FPU_ISSUE_SPLITDIV_EN
    if (bus.reqOp == OP_DIV) issue_op = OP_RCP;
`endif
  end

  fpu_fp32_lat_lut #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_RCP (LAT_RCP),
    .LAT_DIV (LAT_DIV),
    .LAT_SMP (LAT_SMP)
  ) u_lat_lut (
    .op  (issue_op),
    .lat (lat)
  );

  // reqReady stays low while rst_n is asserted so that every output is 0 in reset.
  assign ready    = rst_n && (state_q == ST_IDLE);
  assign accept   = bus.reqValid && ready && !bus.flush;
  assign cnt_zero = (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    counting = 1'b0;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_EXEC;
        ST_EXEC: begin
          counting = 1'b1;
          if (cnt_zero) begin
`ifdef FPU_ISSUE_SPLITDIV_EN
            state_d = split_q ? ST_DIVM : ST_RESP;
`else
            state_d = ST_RESP;
`endif
          end
        end
`ifdef FPU_ISSUE_SPLITDIV_EN
        ST_DIVM: begin
          counting = 1'b1;
          if (cnt_zero) state_d = ST_RESP;
        end
`endif
        ST_RESP: if (bus.rspReady) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      src_a_q <= 32'd0;
      src_b_q <= 32'd0;
      tag_q   <= '0;
      data_q  <= 32'd0;
`ifdef FPU_ISSUE_SPLITDIV_EN
      split_q <= 1'b0;
      rcp_q   <= 32'd0;
`endif
    end else begin
      if (accept) begin
        op_q    <= issue_op;
        src_a_q <= bus.reqSrcA;
        src_b_q <= bus.reqSrcB;
        tag_q   <= bus.reqTag;
        cnt_q   <= lat - 4'd1;
`ifdef FPU_ISSUE_SPLITDIV_EN
        split_q <= (bus.reqOp == OP_DIV);
`endif
      end
`ifdef FPU_ISSUE_SPLITDIV_EN
      else if (state_q == ST_EXEC && state_d == ST_DIVM) begin
        rcp_q <= fpuDst;
        cnt_q <= 4'(LAT_MUL - 1);
      end
`endif
      else if (counting && !cnt_zero) begin
        cnt_q <= cnt_q - 4'd1;
      end

      // A flush forces state_d to IDLE, so an aborted op never lands here.
      if (state_q != ST_RESP && state_d == ST_RESP) data_q <= fpuDst;
    end
  end

  always_comb begin
    fpuOpMode = 4'd0;
    fpuSrcA   = src_a_q;
    fpuSrcB   = src_b_q;
    case (state_q)
      ST_EXEC: fpuOpMode = op_q;
`ifdef FPU_ISSUE_SPLITDIV_EN
      ST_DIVM: begin
        fpuOpMode = OP_MUL;
        fpuSrcB   = rcp_q;
      end
`endif
      default: fpuOpMode = 4'd0;
    endcase
  end

  assign bus.reqReady = ready;
  assign bus.rspValid = (state_q == ST_RESP);
  assign bus.rspData  = data_q;
  assign bus.rspTag   = tag_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_fp32_issue.sv
module tb_fpu_fp32_issue;
  import fpu_fp32_pkg::*;

  localparam int TAG_W = 4;
  localparam int L_ADD = 2;
  localparam int L_MUL = 2;
  localparam int L_RCP = 2;
  localparam int L_DIV = 4;
  localparam int L_SMP = 1;
`ifdef FPU_ISSUE_SPLITDIV_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  fpuOpMode;
  logic [31:0] fpuSrcA;
  logic [31:0] fpuSrcB;
  logic [31:0] fpuDst;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic        pend_en = 1'b0;
  logic [3:0]  pend_op;
  logic [31:0] pend_a;
  logic [31:0] pend_b;
  logic [3:0]  pend_tag;

  fpu_fp32_issue_if #(.TAG_W(TAG_W)) bus ();

  fpu_fp32_issue #(
    .TAG_W(TAG_W), .LAT_ADD(L_ADD), .LAT_MUL(L_MUL),
    .LAT_RCP(L_RCP), .LAT_DIV(L_DIV), .LAT_SMP(L_SMP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fpuOpMode (fpuOpMode),
    .fpuSrcA   (fpuSrcA),
    .fpuSrcB   (fpuSrcB),
    .fpuDst    (fpuDst),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // FP32 <-> real for the values this bench uses (normal numbers and zero).
  function automatic real f2r(input logic [31:0] x);
    real v;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic s;
    int   e;
    int   m;
    real  a;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 8388608.0);
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return r2f(f2r(a) + f2r(b));
      OP_SUB:  return r2f(f2r(a) - f2r(b));
      OP_MUL:  return r2f(f2r(a) * f2r(b));
      OP_DIV:  return r2f(f2r(a) / f2r(b));
      OP_ABS:  return {1'b0, a[30:0]};
      OP_NEG:  return {~a[31], a[30:0]};
      OP_RCP:  return r2f(1.0 / f2r(b));
      OP_SQRT: return r2f($sqrt(f2r({1'b0, a[30:0]})));
      default: return b;
    endcase
  endfunction

  // Request-level latency as seen by the pipeline.
  function automatic int exp_lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return L_ADD;
      4'd3:       return L_MUL;
      4'd4:       return SPLIT ? (L_RCP + L_MUL) : L_DIV;
      4'd7:       return L_RCP;
      default:    return L_SMP;
    endcase
  endfunction

  // FPU-side latency for an opMode value.
  function automatic int stub_lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return L_ADD;
      4'd3:       return L_MUL;
      4'd4:       return L_DIV;
      4'd7:       return L_RCP;
      default:    return L_SMP;
    endcase
  endfunction

  // FPU stub: dst is only correct once the inputs have been stable for the op latency.
  logic [67:0] hist [16];
  logic [67:0] cur;
  logic        stub_ok;
  assign cur = {fpuOpMode, fpuSrcA, fpuSrcB};

  always @(posedge clk) begin
    hist[0] <= cur;
    for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    stub_ok = 1'b1;
    for (int i = 0; i < 15; i++)
      if (i < stub_lat(fpuOpMode) - 1 && hist[i] !== cur) stub_ok = 1'b0;
    fpuDst = stub_ok ? fp_calc(fpuOpMode, fpuSrcA, fpuSrcB) : 32'hDEADBEEF;
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input int hold, input string nm);
    int          cyc;
    int          n_first;
    int          first_lat;
    logic [3:0]  first_op;
    logic [3:0]  last_op;
    logic [31:0] last_b;
    logic [31:0] exp_d;
    bit          split_div;
    split_div = SPLIT && (op == OP_DIV);
    first_op  = split_div ? OP_RCP : op;
    first_lat = split_div ? L_RCP : exp_lat(op);
    exp_d     = fp_calc(op, a, b);
    last_op   = 4'd0;
    last_b    = 32'd0;
    bus.reqValid = 1'b1;
    bus.reqOp    = op;
    bus.reqSrcA  = a;
    bus.reqSrcB  = b;
    bus.reqTag   = tag;
    bus.rspReady = 1'b1;
    cyc = 0;
    while (!bus.reqReady && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check({nm, " req_ready_wait"}, 32'(bus.reqReady), 32'd1);
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    check({nm, " req_ready_low"}, 32'(bus.reqReady), 32'd0);
    check({nm, " busy"}, 32'(busy), 32'd1);
    check({nm, " fpu_src_a"}, fpuSrcA, a);
    check({nm, " first_opmode"}, 32'(fpuOpMode), 32'(first_op));
    cyc = 0;
    n_first = 0;
    while (!bus.rspValid && cyc < 40) begin
      if (fpuOpMode == first_op) n_first++;
      last_op = fpuOpMode;
      last_b  = fpuSrcB;
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " latency"}, 32'(cyc), 32'(exp_lat(op)));
    check({nm, " first_phase_len"}, 32'(n_first), 32'(first_lat));
    if (split_div) begin
      check({nm, " div_mul_op"}, 32'(last_op), 32'(OP_MUL));
      check({nm, " div_mul_srcb"}, last_b, fp_calc(OP_RCP, 32'd0, b));
    end else begin
      check({nm, " last_opmode"}, 32'(last_op), 32'(first_op));
    end
    check({nm, " rsp_data"}, bus.rspData, exp_d);
    check({nm, " rsp_tag"}, 32'(bus.rspTag), 32'(tag));
    check({nm, " resp_opmode"}, 32'(fpuOpMode), 32'd0);
    bus.rspReady = (hold == 0);
    for (int k = 0; k < hold; k++) begin
      if (pend_en) begin
        bus.reqValid = 1'b1;
        bus.reqOp    = pend_op;
        bus.reqSrcA  = pend_a;
        bus.reqSrcB  = pend_b;
        bus.reqTag   = pend_tag;
      end
      @(posedge clk); #1;
      check({nm, " hold_valid"}, 32'(bus.rspValid), 32'd1);
      check({nm, " hold_data"}, bus.rspData, exp_d);
      check({nm, " hold_tag"}, 32'(bus.rspTag), 32'(tag));
      check({nm, " hold_req_ready"}, 32'(bus.reqReady), 32'd0);
    end
    bus.rspReady = 1'b1;
    @(posedge clk); #1;
    check({nm, " post_rsp_valid"}, 32'(bus.rspValid), 32'd0);
    check({nm, " post_busy"}, 32'(busy), 32'd0);
    check({nm, " post_req_ready"}, 32'(bus.reqReady), 32'd1);
  endtask

  logic [31:0] vals [10];
  logic [31:0] pow2 [5];

  initial begin
    int seen;
    int cyc;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000,
             32'h3FC00000, 32'hC0000000, 32'h40C00000, 32'hBF800000, 32'h3E800000};
    pow2 = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h3F000000, 32'hC0000000};

    bus.reqValid = 1'b0;
    bus.reqOp    = 4'd0;
    bus.reqSrcA  = 32'd0;
    bus.reqSrcB  = 32'd0;
    bus.reqTag   = 4'd0;
    bus.flush    = 1'b0;
    bus.rspReady = 1'b1;

    #1;
    check("rst req_ready", 32'(bus.reqReady), 32'd0);
    check("rst rsp_valid", 32'(bus.rspValid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst opmode", 32'(fpuOpMode), 32'd0);
    check("rst rsp_data", bus.rspData, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_rel req_ready", 32'(bus.reqReady), 32'd1);
    @(posedge clk); #1;

    do_op(OP_ADD, 32'h3F800000, 32'h40000000, 4'd3, 0, "add");
    check("add result", 32'h40400000, fp_calc(OP_ADD, 32'h3F800000, 32'h40000000));
    do_op(OP_NEG, 32'h3F800000, 32'h0, 4'd5, 0, "neg");
    do_op(OP_ABS, 32'hC0000000, 32'h0, 4'd6, 1, "abs");
    do_op(OP_DIV, 32'h40C00000, 32'h40000000, 4'd9, 0, "div");

    pend_en  = 1'b1;
    pend_op  = OP_MUL;
    pend_a   = 32'h40400000;
    pend_b   = 32'h40000000;
    pend_tag = 4'd12;
    do_op(OP_SUB, 32'h40800000, 32'h3F800000, 4'd11, 5, "backpressure");
    pend_en = 1'b0;
    do_op(pend_op, pend_a, pend_b, pend_tag, 0, "second_after_bp");

    // flush in the 2nd EXEC cycle of a DIV
    bus.reqValid = 1'b1; bus.reqOp = OP_DIV; bus.reqSrcA = 32'h40C00000;
    bus.reqSrcB = 32'h40000000; bus.reqTag = 4'd1;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_exec busy", 32'(busy), 32'd0);
    check("flush_exec opmode", 32'(fpuOpMode), 32'd0);
    check("flush_exec req_ready", 32'(bus.reqReady), 32'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.rspValid) seen++;
      @(posedge clk); #1;
    end
    check("flush_exec no_rsp", 32'(seen), 32'd0);

    // flush while the response is pending
    bus.reqValid = 1'b1; bus.reqOp = OP_ADD; bus.reqSrcA = 32'h3F800000;
    bus.reqSrcB = 32'h3F800000; bus.reqTag = 4'd2; bus.rspReady = 1'b0;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    cyc = 0;
    while (!bus.rspValid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("flush_resp reached", 32'(bus.rspValid), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.rspReady = 1'b1;
    check("flush_resp rsp_valid", 32'(bus.rspValid), 32'd0);
    check("flush_resp busy", 32'(busy), 32'd0);

    // flush in IDLE blocks the accept
    bus.reqValid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.reqValid = 1'b0; bus.flush = 1'b0;
    check("flush_idle busy", 32'(busy), 32'd0);

    // async reset mid-EXEC
    bus.reqValid = 1'b1; bus.reqOp = OP_DIV; bus.reqSrcA = 32'h40C00000;
    bus.reqSrcB = 32'h40000000; bus.reqTag = 4'd4;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    check("rst_mid busy_before", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid rsp_valid", 32'(bus.rspValid), 32'd0);
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid opmode", 32'(fpuOpMode), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1;
    check("rst_mid req_ready", 32'(bus.reqReady), 32'd1);
    @(posedge clk); #1;
    do_op(OP_ADD, 32'h40000000, 32'h40400000, 4'd7, 0, "add_after_rst");

    for (int n = 0; n < 40; n++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = vals[$urandom_range(0, 9)];
      r_b  = (r_op == OP_DIV) ? pow2[$urandom_range(0, 4)] : vals[$urandom_range(0, 9)];
      do_op(r_op, r_a, r_b, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
